carrier_seq_ctrl: RTL and testbench

// - Sequencer for a bank of N carrier channels (16-bit PWM carrier + mask/event logic per channel).
// - Sequences start and stop, and gives every channel one coherent period/initcarr set.
// - Start: loads the configuration, waits for the shadow registers to settle, then enables all channels in the same cycle.
// - Stop is graceful: each channel stops at its own mask event.
// - Runtime updates are applied on the master (ch0) mask event and acknowledged to the register-bank side.

---
 rtl/carrier_seq_ctrl.sv | 165 ++++++++++++++++
 tb/tb_carrier_seq_ctrl.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/carrier_seq_ctrl.sv
// Start/stop/update sequencer for a bank of N_CARR PWM carrier channels.
// Optional stop watchdog is built when CARR_STOP_TIMEOUT_EN is defined.
module carrier_seq_ctrl #(
  parameter int unsigned N_CARR         = 8,
  parameter int unsigned CW             = 16,
  parameter int unsigned ARM_CYCLES     = 2,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start_req,
  input  logic                 stop_req,
  input  logic                 upd_req,
  input  logic [CW-1:0]        period_in,
  input  logic [N_CARR*CW-1:0] phase_in,
  input  logic [N_CARR-1:0]    maskevent,
  output logic [N_CARR-1:0]    pwm_onoff,
  output logic [CW-1:0]        period_out,
  output logic [N_CARR*CW-1:0] initcarr_out,
  output logic                 upd_ack,
  output logic                 busy,
  output logic                 done,
  output logic                 cfg_err,
  output logic                 stop_timeout
);

  typedef enum logic [2:0] {StIdle, StLoad, StArm, StRun, StStop} state_e;

  state_e               state_q, state_d;
  logic [3:0]           arm_cnt_q, arm_cnt_d;
  logic [N_CARR-1:0]    pwm_q, pwm_d;
  logic [CW-1:0]        period_q, period_d;
  logic [N_CARR*CW-1:0] initcarr_q, initcarr_d;
  logic                 upd_ack_q, upd_ack_d;
  logic                 done_q, done_d;
  logic                 cfg_err_q, cfg_err_d;
  logic                 tmo_flag_q, tmo_flag_d;
  logic [N_CARR*CW-1:0] clamp_phase;
  logic                 clamp_err;
  logic                 tmo_hit;

`ifdef CARR_STOP_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_cnt_q;

  // Counts cycles spent in STOP; zeroed on every other state so each entry restarts it.
  always_ff @(posedge clk) begin
    if (reset || state_q != StStop) tmo_cnt_q <= '0;
    else                            tmo_cnt_q <= tmo_cnt_q + TW'(1);
  end
  assign tmo_hit = (state_q == StStop) && (tmo_cnt_q == TW'(TIMEOUT_CYCLES - 1));
`else
  logic unused_tmo;
  assign unused_tmo = ^TIMEOUT_CYCLES;
  assign tmo_hit    = 1'b0;
`endif

  // A phase is legal only below the period; period 0 therefore clamps everything.
  always_comb begin
    clamp_phase = '0;
    clamp_err   = 1'b0;
    for (int k = 0; k < int'(N_CARR); k++) begin
      if (phase_in[k*CW +: CW] < period_in) clamp_phase[k*CW +: CW] = phase_in[k*CW +: CW];
      else                                  clamp_err = 1'b1;
    end
  end

  always_comb begin
    state_d    = state_q;
    arm_cnt_d  = arm_cnt_q;
    pwm_d      = pwm_q;
    period_d   = period_q;
    initcarr_d = initcarr_q;
    upd_ack_d  = 1'b0;
    done_d     = 1'b0;
    cfg_err_d  = cfg_err_q;
    tmo_flag_d = tmo_flag_q;
    unique case (state_q)
      StIdle: begin
        pwm_d = '0;
        if (start_req && !stop_req) begin
          state_d   = StLoad;
          cfg_err_d = 1'b0;
        end
      end
      StLoad: begin
        if (stop_req) begin
          state_d = StIdle;
        end else begin
          period_d   = period_in;
          initcarr_d = clamp_phase;
          if (clamp_err) cfg_err_d = 1'b1;
          arm_cnt_d  = '0;
          state_d    = StArm;
        end
      end
      StArm: begin
        if (stop_req) begin
          state_d = StIdle;
        end else if (arm_cnt_q == 4'(ARM_CYCLES - 1)) begin
          state_d = StRun;
          pwm_d   = '1;
        end else begin
          arm_cnt_d = arm_cnt_q + 4'd1;
        end
      end
      StRun: begin
        if (stop_req) begin
          state_d = StStop;
        end else if (upd_req && maskevent[0]) begin
          period_d   = period_in;
          initcarr_d = clamp_phase;
          if (clamp_err) cfg_err_d = 1'b1;
          upd_ack_d  = 1'b1;
        end
      end
      StStop: begin
        pwm_d = pwm_q & ~maskevent;
        if (tmo_hit) begin
          pwm_d      = '0;
          tmo_flag_d = 1'b1;
        end
        if (pwm_d == '0) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      arm_cnt_q  <= '0;
      pwm_q      <= '0;
      period_q   <= '0;
      initcarr_q <= '0;
      upd_ack_q  <= 1'b0;
      done_q     <= 1'b0;
      cfg_err_q  <= 1'b0;
      tmo_flag_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      arm_cnt_q  <= arm_cnt_d;
      pwm_q      <= pwm_d;
      period_q   <= period_d;
      initcarr_q <= initcarr_d;
      upd_ack_q  <= upd_ack_d;
      done_q     <= done_d;
      cfg_err_q  <= cfg_err_d;
      tmo_flag_q <= tmo_flag_d;
    end
  end

  assign pwm_onoff    = pwm_q;
  assign period_out   = period_q;
  assign initcarr_out = initcarr_q;
  assign upd_ack      = upd_ack_q;
  assign busy         = (state_q != StIdle);
  assign done         = done_q;
  assign cfg_err      = cfg_err_q;
  assign stop_timeout = tmo_flag_q;

endmodule

// File: tb/tb_carrier_seq_ctrl.sv
// Directed bench for carrier_seq_ctrl; inputs driven and outputs sampled 1ns after posedge.
module tb_carrier_seq_ctrl;
  localparam int N  = 8;
  localparam int CW = 16;

  logic            clk = 1'b0;
  logic            reset, start_req, stop_req, upd_req;
  logic [CW-1:0]   period_in;
  logic [N*CW-1:0] phase_in;
  logic [N-1:0]    maskevent;
  logic [N-1:0]    pwm_onoff;
  logic [CW-1:0]   period_out;
  logic [N*CW-1:0] initcarr_out;
  logic            upd_ack, busy, done, cfg_err, stop_timeout;

  int pass_cnt = 0;
  int total    = 0;

  carrier_seq_ctrl #(
    .N_CARR(N), .CW(CW), .ARM_CYCLES(2), .TIMEOUT_CYCLES(100)
  ) dut (
    .clk(clk), .reset(reset), .start_req(start_req), .stop_req(stop_req), .upd_req(upd_req),
    .period_in(period_in), .phase_in(phase_in), .maskevent(maskevent), .pwm_onoff(pwm_onoff),
    .period_out(period_out), .initcarr_out(initcarr_out), .upd_ack(upd_ack), .busy(busy),
    .done(done), .cfg_err(cfg_err), .stop_timeout(stop_timeout)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_phases();
    for (int k = 0; k < N; k++) phase_in[k*CW +: CW] = 16'(k * 125);
  endtask

  task automatic go_run();
    start_req = 1'b1; tick(); start_req = 1'b0;
    repeat (3) tick();
  endtask

  task automatic stop_all();
    stop_req = 1'b1; tick(); stop_req = 1'b0;
    maskevent = '1; tick(); maskevent = '0;
    tick();
  endtask

  task automatic test_reset();
    total++; if ({pwm_onoff, period_out, initcarr_out, upd_ack, done, cfg_err, stop_timeout} !== '0)
      $display("FAIL reset_outputs: got pwm=%h per=%0d ic=%h ack=%b done=%b err=%b tmo=%b want all 0",
               pwm_onoff, period_out, initcarr_out, upd_ack, done, cfg_err, stop_timeout);
    else pass_cnt++;
    total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else pass_cnt++;
  endtask

  task automatic test_start();
    logic [N*CW-1:0] exp_ic;
    for (int k = 0; k < N; k++) exp_ic[k*CW +: CW] = 16'(k * 125);
    period_in = 16'd1000; set_phases();
    start_req = 1'b1; tick(); start_req = 1'b0;
    total++; if (busy !== 1'b1 || pwm_onoff !== 8'h00)
      $display("FAIL start_load: got busy=%b pwm=%h want 1/00", busy, pwm_onoff); else pass_cnt++;
    tick();
    total++; if (period_out !== 16'd1000) $display("FAIL start_period: got %0d want 1000", period_out);
    else pass_cnt++;
    total++; if (initcarr_out !== exp_ic)
      $display("FAIL start_initcarr: got %h want %h", initcarr_out, exp_ic); else pass_cnt++;
    total++; if (pwm_onoff !== 8'h00) $display("FAIL start_arm1: got %h want 00", pwm_onoff);
    else pass_cnt++;
    tick();
    total++; if (pwm_onoff !== 8'h00) $display("FAIL start_arm2: got %h want 00", pwm_onoff);
    else pass_cnt++;
    tick();
    total++; if (pwm_onoff !== 8'hff) $display("FAIL start_run: got %h want ff", pwm_onoff);
    else pass_cnt++;
    total++; if (cfg_err !== 1'b0) $display("FAIL start_cfg_err: got %b want 0", cfg_err);
    else pass_cnt++;
  endtask

  task automatic test_update();
    logic bad = 1'b0;
    logic [N*CW-1:0] exp_ic = '0;
    for (int k = 0; k < 4; k++) exp_ic[k*CW +: CW] = 16'(k * 125);
    period_in = 16'd500; upd_req = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (period_out !== 16'd1000 || upd_ack !== 1'b0 || pwm_onoff !== 8'hff) bad = 1'b1;
    end
    total++; if (bad !== 1'b0) $display("FAIL upd_hold: got changed outputs want stable");
    else pass_cnt++;
    maskevent = 8'h01; tick(); maskevent = '0; upd_req = 1'b0;
    total++; if (period_out !== 16'd500 || upd_ack !== 1'b1)
      $display("FAIL upd_apply: got per=%0d ack=%b want 500/1", period_out, upd_ack); else pass_cnt++;
    total++; if (initcarr_out !== exp_ic || cfg_err !== 1'b1)
      $display("FAIL upd_clamp: got ic=%h err=%b want %h/1", initcarr_out, cfg_err, exp_ic);
    else pass_cnt++;
    tick();
    total++; if (upd_ack !== 1'b0) $display("FAIL upd_ack_pulse: got %b want 0", upd_ack);
    else pass_cnt++;
  endtask

  task automatic test_stop();
    logic [N-1:0] exp_pwm = 8'hff;
    stop_req = 1'b1; maskevent = 8'hff; tick(); stop_req = 1'b0; maskevent = '0;
    total++; if (pwm_onoff !== 8'hff || busy !== 1'b1)
      $display("FAIL stop_entry: got pwm=%h busy=%b want ff/1", pwm_onoff, busy); else pass_cnt++;
    for (int k = 0; k < N; k++) begin
      stop_req = (k == 2); tick(); stop_req = 1'b0;
      maskevent = 8'(1 << k); tick(); maskevent = '0;
      exp_pwm[k] = 1'b0;
      total++; if (pwm_onoff !== exp_pwm || done !== (k == N - 1))
        $display("FAIL stop_ch%0d: got pwm=%h done=%b want %h/%b", k, pwm_onoff, done, exp_pwm,
                 k == N - 1);
      else pass_cnt++;
    end
    total++; if (busy !== 1'b0) $display("FAIL stop_busy: got %b want 0", busy); else pass_cnt++;
    tick();
    total++; if (done !== 1'b0) $display("FAIL stop_done_pulse: got %b want 0", done);
    else pass_cnt++;
  endtask

  task automatic test_clamp();
    period_in = 16'd1000; set_phases(); phase_in[3*CW +: CW] = 16'd1200;
    start_req = 1'b1; tick(); start_req = 1'b0; tick();
    total++; if (initcarr_out[3*CW +: CW] !== 16'd0 || cfg_err !== 1'b1)
      $display("FAIL clamp_load: got ic3=%0d err=%b want 0/1", initcarr_out[3*CW +: CW], cfg_err);
    else pass_cnt++;
    total++; if (initcarr_out[4*CW +: CW] !== 16'd500)
      $display("FAIL clamp_other: got %0d want 500", initcarr_out[4*CW +: CW]); else pass_cnt++;
    repeat (2) tick();
    total++; if (cfg_err !== 1'b1 || pwm_onoff !== 8'hff)
      $display("FAIL clamp_sticky: got err=%b pwm=%h want 1/ff", cfg_err, pwm_onoff); else pass_cnt++;
    stop_all();
    set_phases();
    start_req = 1'b1; tick(); start_req = 1'b0;
    total++; if (cfg_err !== 1'b0) $display("FAIL clamp_clear: got %b want 0", cfg_err);
    else pass_cnt++;
    repeat (3) tick();
  endtask

  task automatic test_collisions();
    period_in = 16'd700; upd_req = 1'b1; maskevent = 8'h01; stop_req = 1'b1;
    tick(); upd_req = 1'b0; maskevent = '0; stop_req = 1'b0;
    total++; if (upd_ack !== 1'b0 || period_out !== 16'd1000 || busy !== 1'b1)
      $display("FAIL coll_run: got ack=%b per=%0d busy=%b want 0/1000/1", upd_ack, period_out, busy);
    else pass_cnt++;
    maskevent = '1; tick(); maskevent = '0; tick();
    start_req = 1'b1; stop_req = 1'b1; tick(); start_req = 1'b0; stop_req = 1'b0;
    total++; if (busy !== 1'b0) $display("FAIL coll_idle: got busy=%b want 0", busy); else pass_cnt++;
    upd_req = 1'b1; maskevent = 8'h01; repeat (2) tick(); upd_req = 1'b0; maskevent = '0;
    total++; if (upd_ack !== 1'b0 || busy !== 1'b0)
      $display("FAIL coll_upd_idle: got ack=%b busy=%b want 0/0", upd_ack, busy); else pass_cnt++;
    start_req = 1'b1; tick(); start_req = 1'b0; stop_req = 1'b1; tick(); stop_req = 1'b0;
    total++; if (busy !== 1'b0 || done !== 1'b0)
      $display("FAIL coll_load_stop: got busy=%b done=%b want 0/0", busy, done); else pass_cnt++;
  endtask

  task automatic test_watchdog();
    go_run();
    stop_req = 1'b1; tick(); stop_req = 1'b0;
    maskevent = 8'hdf; tick(); maskevent = '0;
`ifdef CARR_STOP_TIMEOUT_EN
    repeat (98) tick();
    total++; if (pwm_onoff !== 8'h20 || done !== 1'b0 || stop_timeout !== 1'b0)
      $display("FAIL wd_pre: got pwm=%h done=%b tmo=%b want 20/0/0", pwm_onoff, done, stop_timeout);
    else pass_cnt++;
    tick();
    total++; if (pwm_onoff !== 8'h00 || done !== 1'b1 || stop_timeout !== 1'b1 || busy !== 1'b0)
      $display("FAIL wd_fire: got pwm=%h done=%b tmo=%b busy=%b want 00/1/1/0", pwm_onoff, done,
               stop_timeout, busy);
    else pass_cnt++;
    tick();
    total++; if (done !== 1'b0 || stop_timeout !== 1'b1)
      $display("FAIL wd_after: got done=%b tmo=%b want 0/1", done, stop_timeout); else pass_cnt++;
`else
    repeat (150) tick();
    total++; if (pwm_onoff !== 8'h20 || busy !== 1'b1 || stop_timeout !== 1'b0)
      $display("FAIL wd_none: got pwm=%h busy=%b tmo=%b want 20/1/0", pwm_onoff, busy, stop_timeout);
    else pass_cnt++;
`endif
    reset = 1'b1; tick(); reset = 1'b0;
  endtask

  task automatic test_reset_run();
    go_run();
    total++; if (pwm_onoff !== 8'hff) $display("FAIL rst_pre: got %h want ff", pwm_onoff);
    else pass_cnt++;
    reset = 1'b1; tick(); reset = 1'b0;
    test_reset();
  endtask

  initial begin
    reset = 1'b1; start_req = 1'b0; stop_req = 1'b0; upd_req = 1'b0;
    period_in = '0; phase_in = '0; maskevent = '0;
    repeat (2) tick();
    reset = 1'b0;
    test_reset();
    test_start();
    test_update();
    test_stop();
    test_clamp();
    test_collisions();
    test_watchdog();
    test_reset_run();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
